jtcps2_eeprom: RTL and testbench



---
 rtl/jtcps2_eeprom_pkg.sv | 21 ++
 rtl/jtcps2_eeprom_mem.sv | 40 ++++
 rtl/jtcps2_eeprom.sv | 216 +++++++++++++++++++++
 tb/tb_jtcps2_eeprom.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtcps2_eeprom_pkg.sv
// rtl/jtcps2_eeprom_pkg.sv - shared opcodes, states and sizes for the 93C46 EEPROM model
package jtcps2_eeprom_pkg;

    localparam int WORDS = 64;

    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_ERASE = 2'b11;
    localparam logic [1:0] OP_EXT   = 2'b00;

    localparam logic [1:0] EXT_EWDS = 2'b00;
    localparam logic [1:0] EXT_WRAL = 2'b01;
    localparam logic [1:0] EXT_ERAL = 2'b10;
    localparam logic [1:0] EXT_EWEN = 2'b11;

    typedef enum logic [2:0] {IDLE, OPC, ADDR, DIN, DOUT, HOLD, BUSY} state_t;

    // Array operation committed when scs falls in HOLD
    typedef enum logic [2:0] {PEND_NONE, PEND_WRITE, PEND_ERASE, PEND_ERAL, PEND_WRAL} pend_t;

endpackage

// File: rtl/jtcps2_eeprom_mem.sv
// rtl/jtcps2_eeprom_mem.sv - 64x16 array with serial word write/read and registered host byte port
module jtcps2_eeprom_mem #(
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [15:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [15:0]   rdata,
    input  logic [AW:0]   host_addr,
    input  logic [7:0]    host_din,
    input  logic          host_we,
    output logic [7:0]    host_dout
);

    logic [15:0] mem [0:(1<<AW)-1];

    assign rdata = mem[raddr];

    // Contents survive reset on purpose: this is the NVRAM
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end else if (host_we) begin
            if (host_addr[0]) mem[host_addr[AW:1]][7:0]  <= host_din;
            else              mem[host_addr[AW:1]][15:8] <= host_din;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            host_dout <= 8'h00;
        end else begin
            host_dout <= host_addr[0] ? mem[host_addr[AW:1]][7:0] : mem[host_addr[AW:1]][15:8];
        end
    end

endmodule

// File: rtl/jtcps2_eeprom.sv
// rtl/jtcps2_eeprom.sv - 93C46-style serial EEPROM responder; host dump port enabled by JTCPS2_EEPROM_DUMP_EN
module jtcps2_eeprom
    import jtcps2_eeprom_pkg::*;
#(
    parameter int BUSY_CYC = 2048,
    parameter int AW       = 6
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       scs,
    input  logic       sclk,
    input  logic       sdi,
    output logic       sdo,
    input  logic [6:0] dump_addr,
    input  logic [7:0] dump_din,
    input  logic       dump_we,
    output logic [7:0] dump_dout,
    output logic       dump_change
);

    localparam int BW = $clog2(BUSY_CYC) + 1;

    state_t          st;
    pend_t           pend;
    logic            sclk_l, scs_l, rise, cs_fall, wen, chg;
    logic [3:0]      cnt;
    logic [1:0]      opc;
    logic [AW-1:0]   addr, addr_nx, raddr, mem_waddr;
    logic [15:0]     sr, din, rdata, mem_wdata;
    logic [BW-1:0]   busy_cnt;
    logic            mem_we, host_we;
    logic [7:0]      host_dout;

    assign rise    = sclk & ~sclk_l;
    assign cs_fall = ~scs & scs_l;
    assign addr_nx = {addr[AW-2:0], sdi};
    // The last address rise needs the word at the address being completed
    assign raddr   = (st == ADDR) ? addr_nx : addr + AW'(1);

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = addr;
        mem_wdata = din;
        if (st == BUSY) begin
            case (pend)
                PEND_WRITE: mem_we = (busy_cnt == '0);
                PEND_ERASE: begin
                    mem_we    = (busy_cnt == '0);
                    mem_wdata = 16'hFFFF;
                end
                PEND_ERAL: begin
                    mem_we    = (busy_cnt < BW'(WORDS));
                    mem_waddr = busy_cnt[AW-1:0];
                    mem_wdata = 16'hFFFF;
                end
                PEND_WRAL: begin
                    mem_we    = (busy_cnt < BW'(WORDS));
                    mem_waddr = busy_cnt[AW-1:0];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st       <= IDLE;
            pend     <= PEND_NONE;
            sclk_l   <= 1'b0;
            scs_l    <= 1'b0;
            wen      <= 1'b0;
            chg      <= 1'b0;
            sdo      <= 1'b1;
            cnt      <= 4'd0;
            opc      <= 2'b00;
            addr     <= '0;
            sr       <= 16'h0000;
            din      <= 16'h0000;
            busy_cnt <= '0;
        end else begin
            sclk_l <= sclk;
            scs_l  <= scs;
            chg    <= 1'b0;
            case (st)
                IDLE: begin
                    sdo <= 1'b1;
                    if (rise && scs && sdi) begin
                        st  <= OPC;
                        cnt <= 4'd0;
                    end
                end
                OPC: begin
                    if (cs_fall) begin
                        st <= IDLE;
                    end else if (rise) begin
                        opc <= {opc[0], sdi};
                        cnt <= cnt + 4'd1;
                        if (cnt == 4'd1) begin
                            st  <= ADDR;
                            cnt <= 4'd0;
                        end
                    end
                end
                ADDR: begin
                    if (cs_fall) begin
                        st <= IDLE;
                    end else if (rise) begin
                        addr <= addr_nx;
                        cnt  <= cnt + 4'd1;
                        if (cnt == 4'(AW-1)) begin
                            cnt  <= 4'd0;
                            pend <= PEND_NONE;
                            st   <= HOLD;
                            case (opc)
                                OP_READ: begin
                                    sr  <= rdata;
                                    sdo <= 1'b0;
                                    st  <= DOUT;
                                end
                                OP_WRITE: begin
                                    pend <= PEND_WRITE;
                                    st   <= DIN;
                                end
                                OP_ERASE: pend <= PEND_ERASE;
                                default: begin
                                    case (addr_nx[AW-1:AW-2])
                                        EXT_EWEN: wen  <= 1'b1;
                                        EXT_EWDS: wen  <= 1'b0;
                                        EXT_ERAL: pend <= PEND_ERAL;
                                        default: begin
                                            pend <= PEND_WRAL;
                                            st   <= DIN;
                                        end
                                    endcase
                                end
                            endcase
                        end
                    end
                end
                DIN: begin
                    if (cs_fall) begin
                        st <= IDLE;
                    end else if (rise) begin
                        din <= {din[14:0], sdi};
                        cnt <= cnt + 4'd1;
                        if (cnt == 4'd15) st <= HOLD;
                    end
                end
                DOUT: begin
                    if (cs_fall) begin
                        st  <= IDLE;
                        sdo <= 1'b1;
                    end else if (rise) begin
                        sdo <= sr[15];
                        cnt <= cnt + 4'd1;
                        if (cnt == 4'd15) begin
                            addr <= addr + AW'(1);
                            sr   <= rdata;
                        end else begin
                            sr <= {sr[14:0], 1'b0};
                        end
                    end
                end
                HOLD: begin
                    if (cs_fall) begin
                        if (pend != PEND_NONE && wen) begin
                            st       <= BUSY;
                            sdo      <= 1'b0;
                            busy_cnt <= '0;
                        end else begin
                            st <= IDLE;
                        end
                    end
                end
                BUSY: begin
                    sdo <= 1'b0;
                    chg <= (busy_cnt == '0);
                    if (busy_cnt == BW'(BUSY_CYC - 1)) begin
                        st  <= IDLE;
                        sdo <= 1'b1;
                    end else begin
                        busy_cnt <= busy_cnt + BW'(1);
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

`ifdef JTCPS2_EEPROM_DUMP_EN
    assign host_we     = dump_we & (st == IDLE);
    assign dump_dout   = host_dout;
    assign dump_change = chg;
`else
    logic unused_dump;
    assign host_we     = 1'b0;
    assign dump_dout   = 8'h00;
    assign dump_change = 1'b0;
    assign unused_dump = ^{dump_we, host_dout, chg};
`endif

    jtcps2_eeprom_mem #(.AW(AW)) u_mem (
        .clk       (clk),
        .rstn      (rstn),
        .we        (mem_we),
        .waddr     (mem_waddr),
        .wdata     (mem_wdata),
        .raddr     (raddr),
        .rdata     (rdata),
        .host_addr (dump_addr),
        .host_din  (dump_din),
        .host_we   (host_we),
        .host_dout (host_dout)
    );

endmodule

// File: tb/tb_jtcps2_eeprom.sv
// tb/tb_jtcps2_eeprom.sv - scoreboard bench for jtcps2_eeprom; host checks follow JTCPS2_EEPROM_DUMP_EN
module tb_jtcps2_eeprom;

`ifdef JTCPS2_EEPROM_DUMP_EN
    localparam int CHG = 1;
`else
    localparam int CHG = 0;
`endif

    logic       clk = 1'b0, rstn = 1'b0, scs = 1'b0, sclk = 1'b0, sdi = 1'b0, dump_we = 1'b0;
    logic [6:0] dump_addr = 7'd0;
    logic [7:0] dump_din = 8'd0;
    logic       sdo, dump_change;
    logic [7:0] dump_dout;

    int          n_chk = 0, n_fail = 0;
    logic [15:0] mdl [0:63];
    logic [15:0] exp_q[$];
    logic [15:0] obs_q[$];

    jtcps2_eeprom dut (
        .clk(clk), .rstn(rstn), .scs(scs), .sclk(sclk), .sdi(sdi), .sdo(sdo),
        .dump_addr(dump_addr), .dump_din(dump_din), .dump_we(dump_we),
        .dump_dout(dump_dout), .dump_change(dump_change)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog");
    end

    task automatic bit_rise(input logic b);
        sclk = 1'b0;
        sdi  = b;
        @(negedge clk);
        sclk = 1'b1;
        @(negedge clk);
    endtask

    task automatic send(input logic [1:0] op, input logic [5:0] a, input int ndata, input logic [15:0] d);
        @(negedge clk);
        scs  = 1'b1;
        sclk = 1'b0;
        @(negedge clk);
        bit_rise(1'b1);
        bit_rise(op[1]);
        bit_rise(op[0]);
        for (int i = 5; i >= 0; i--) bit_rise(a[i]);
        for (int i = 0; i < ndata; i++) bit_rise(d[15-i]);
    endtask

    task automatic cs_drop;
        sclk = 1'b0;
        scs  = 1'b0;
    endtask

    task automatic wait_busy(output int nlow, output int nchg);
        nlow = 0;
        nchg = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (dump_change) nchg++;
            if (sdo) break;
            nlow++;
        end
    endtask

    task automatic cmd(input logic [1:0] op, input logic [5:0] a, input int ndata, input logic [15:0] d,
                       output int nlow, output int nchg);
        send(op, a, ndata, d);
        cs_drop;
        wait_busy(nlow, nchg);
    endtask

    task automatic serial_read(input logic [5:0] a, input int nw, output logic dummy);
        logic [15:0] w;
        send(2'b10, a, 0, 16'h0);
        dummy = sdo;
        for (int k = 0; k < nw; k++) begin
            w = 16'h0;
            for (int b = 0; b < 16; b++) begin
                bit_rise(1'b0);
                w = {w[14:0], sdo};
            end
            obs_q.push_back(w);
        end
        cs_drop;
        @(negedge clk);
    endtask

    task automatic host_write(input logic [6:0] a, input logic [7:0] d);
        @(negedge clk);
        dump_addr = a;
        dump_din  = d;
        dump_we   = 1'b1;
        @(negedge clk);
        dump_we   = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_chk++; if (sdo !== 1'b1) begin n_fail++; $display("FAIL reset_sdo_in_reset: got %b expected 1", sdo); end
        rstn = 1'b1;
        @(negedge clk);
        n_chk++; if (sdo !== 1'b1) begin n_fail++; $display("FAIL reset_sdo: got %b expected 1", sdo); end
        n_chk++; if (dump_dout !== 8'h00) begin n_fail++; $display("FAIL reset_dump_dout: got %h expected 00", dump_dout); end
        n_chk++; if (dump_change !== 1'b0) begin n_fail++; $display("FAIL reset_dump_change: got %b expected 0", dump_change); end
    endtask

    task automatic test_write_blocked;
        int nl, nc;
        cmd(2'b01, 6'd3, 16, 16'h1234, nl, nc);
        n_chk++; if (nl !== 0) begin n_fail++; $display("FAIL blocked_busy: got %0d low cycles expected 0", nl); end
        n_chk++; if (nc !== 0) begin n_fail++; $display("FAIL blocked_change: got %0d pulses expected 0", nc); end
    endtask

    task automatic test_eral;
        int nl, nc;
        logic dmy;
        logic [15:0] o, e;
        cmd(2'b00, 6'b110000, 0, 16'h0, nl, nc);
        n_chk++; if (nl !== 0) begin n_fail++; $display("FAIL ewen_busy: got %0d expected 0", nl); end
        cmd(2'b00, 6'b100000, 0, 16'h0, nl, nc);
        n_chk++; if (nl !== 2048) begin n_fail++; $display("FAIL eral_busy: got %0d expected 2048", nl); end
        n_chk++; if (nc !== CHG) begin n_fail++; $display("FAIL eral_change: got %0d expected %0d", nc, CHG); end
        for (int i = 0; i < 64; i++) begin
            mdl[i] = 16'hFFFF;
            exp_q.push_back(mdl[i]);
        end
        serial_read(6'd0, 64, dmy);
        n_chk++; if (dmy !== 1'b0) begin n_fail++; $display("FAIL eral_dummy: got %b expected 0", dmy); end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_chk++; if (o !== e) begin n_fail++; $display("FAIL eral_word: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_write;
        int nl, nc;
        logic dmy;
        logic [15:0] o, e;
        cmd(2'b01, 6'd3, 16, 16'h1234, nl, nc);
        mdl[3] = 16'h1234;
        n_chk++; if (nl !== 2048) begin n_fail++; $display("FAIL write_busy: got %0d expected 2048", nl); end
        n_chk++; if (nc !== CHG) begin n_fail++; $display("FAIL write_change: got %0d expected %0d", nc, CHG); end
        @(negedge clk); dump_addr = 7'd6;
        @(negedge clk);
`ifdef JTCPS2_EEPROM_DUMP_EN
        n_chk++; if (dump_dout !== 8'h12) begin n_fail++; $display("FAIL dump_hi: got %h expected 12", dump_dout); end
        dump_addr = 7'd7;
        @(negedge clk);
        n_chk++; if (dump_dout !== 8'h34) begin n_fail++; $display("FAIL dump_lo: got %h expected 34", dump_dout); end
`else
        n_chk++; if (dump_dout !== 8'h00) begin n_fail++; $display("FAIL dump_tied: got %h expected 00", dump_dout); end
`endif
        exp_q.push_back(mdl[3]);
        serial_read(6'd3, 1, dmy);
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_chk++; if (o !== e) begin n_fail++; $display("FAIL write_word: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_read;
        int nl, nc;
        logic dmy;
        logic [15:0] o, e;
        cmd(2'b01, 6'd5, 16, 16'hA55A, nl, nc);
        mdl[5] = 16'hA55A;
        n_chk++; if (nl !== 2048) begin n_fail++; $display("FAIL read_prep5: got %0d expected 2048", nl); end
        cmd(2'b01, 6'd6, 16, 16'h0F0F, nl, nc);
        mdl[6] = 16'h0F0F;
        n_chk++; if (nl !== 2048) begin n_fail++; $display("FAIL read_prep6: got %0d expected 2048", nl); end
        exp_q.push_back(mdl[5]);
        exp_q.push_back(mdl[6]);
        serial_read(6'd5, 2, dmy);
        n_chk++; if (dmy !== 1'b0) begin n_fail++; $display("FAIL read_dummy: got %b expected 0", dmy); end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_chk++; if (o !== e) begin n_fail++; $display("FAIL read_word: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_ewds;
        int nl, nc;
        logic dmy;
        logic [15:0] o, e;
        cmd(2'b00, 6'b000000, 0, 16'h0, nl, nc);
        cmd(2'b01, 6'd3, 16, 16'hBEEF, nl, nc);
        n_chk++; if (nl !== 0) begin n_fail++; $display("FAIL ewds_busy: got %0d expected 0", nl); end
        cmd(2'b11, 6'd5, 0, 16'h0, nl, nc);
        n_chk++; if (nl !== 0) begin n_fail++; $display("FAIL ewds_erase_busy: got %0d expected 0", nl); end
        exp_q.push_back(mdl[3]);
        exp_q.push_back(mdl[4]);
        exp_q.push_back(mdl[5]);
        serial_read(6'd3, 3, dmy);
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_chk++; if (o !== e) begin n_fail++; $display("FAIL ewds_word: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_abort;
        int nl, nc;
        logic dmy;
        logic [15:0] o, e;
        cmd(2'b00, 6'b110000, 0, 16'h0, nl, nc);
        cmd(2'b01, 6'd7, 8, 16'hAB00, nl, nc);
        n_chk++; if (nl !== 0) begin n_fail++; $display("FAIL abort_busy: got %0d expected 0", nl); end
        n_chk++; if (nc !== 0) begin n_fail++; $display("FAIL abort_change: got %0d expected 0", nc); end
        exp_q.push_back(mdl[7]);
        serial_read(6'd7, 1, dmy);
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_chk++; if (o !== e) begin n_fail++; $display("FAIL abort_word: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_wrap;
        int nl, nc;
        logic dmy;
        logic [15:0] o, e;
        cmd(2'b01, 6'd63, 16, 16'h6363, nl, nc);
        mdl[63] = 16'h6363;
        cmd(2'b01, 6'd0, 16, 16'h1357, nl, nc);
        mdl[0] = 16'h1357;
        cmd(2'b11, 6'd6, 0, 16'h0, nl, nc);
        mdl[6] = 16'hFFFF;
        n_chk++; if (nl !== 2048) begin n_fail++; $display("FAIL erase_busy: got %0d expected 2048", nl); end
        exp_q.push_back(mdl[63]);
        exp_q.push_back(mdl[0]);
        serial_read(6'd63, 2, dmy);
        exp_q.push_back(mdl[5]);
        exp_q.push_back(mdl[6]);
        serial_read(6'd5, 2, dmy);
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_chk++; if (o !== e) begin n_fail++; $display("FAIL wrap_word: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_wral;
        int nl, nc;
        logic dmy;
        logic [15:0] o, e;
        cmd(2'b00, 6'b010000, 16, 16'h00C3, nl, nc);
        n_chk++; if (nl !== 2048) begin n_fail++; $display("FAIL wral_busy: got %0d expected 2048", nl); end
        n_chk++; if (nc !== CHG) begin n_fail++; $display("FAIL wral_change: got %0d expected %0d", nc, CHG); end
        for (int i = 0; i < 64; i++) begin
            mdl[i] = 16'h00C3;
            exp_q.push_back(mdl[i]);
        end
        serial_read(6'd0, 64, dmy);
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_chk++; if (o !== e) begin n_fail++; $display("FAIL wral_word: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_host;
        int nc;
        logic dmy;
        logic [15:0] o, e;
        nc = 0;
        host_write(7'd40, 8'hAB);
        if (dump_change) nc++;
        host_write(7'd41, 8'hCD);
        if (dump_change) nc++;
        @(negedge clk);
        if (dump_change) nc++;
        n_chk++; if (nc !== 0) begin n_fail++; $display("FAIL host_change: got %0d expected 0", nc); end
`ifdef JTCPS2_EEPROM_DUMP_EN
        mdl[20] = 16'hABCD;
        dump_addr = 7'd40;
        @(negedge clk);
        n_chk++; if (dump_dout !== 8'hAB) begin n_fail++; $display("FAIL host_read: got %h expected AB", dump_dout); end
`else
        n_chk++; if (dump_dout !== 8'h00) begin n_fail++; $display("FAIL host_tied: got %h expected 00", dump_dout); end
`endif
        @(negedge clk);
        scs = 1'b1;
        @(negedge clk);
        bit_rise(1'b1);
        host_write(7'd42, 8'h77);
        cs_drop;
        @(negedge clk);
        exp_q.push_back(mdl[20]);
        exp_q.push_back(mdl[21]);
        serial_read(6'd20, 2, dmy);
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_chk++; if (o !== e) begin n_fail++; $display("FAIL host_word: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_reset_busy;
        int nl, nc;
        logic dmy;
        logic [15:0] o, e;
        send(2'b01, 6'd9, 16, 16'h5555);
        cs_drop;
        repeat (10) @(negedge clk);
        n_chk++; if (sdo !== 1'b0) begin n_fail++; $display("FAIL rb_in_busy: got %b expected 0", sdo); end
        mdl[9] = 16'h5555;
        rstn = 1'b0;
        @(negedge clk);
        n_chk++; if (sdo !== 1'b1) begin n_fail++; $display("FAIL rb_sdo: got %b expected 1", sdo); end
        rstn = 1'b1;
        @(negedge clk);
        cmd(2'b01, 6'd10, 16, 16'h1111, nl, nc);
        n_chk++; if (nl !== 0) begin n_fail++; $display("FAIL rb_wen_cleared: got %0d expected 0", nl); end
        exp_q.push_back(mdl[9]);
        exp_q.push_back(mdl[10]);
        serial_read(6'd9, 2, dmy);
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_chk++; if (o !== e) begin n_fail++; $display("FAIL rb_word: got %h expected %h", o, e); end
        end
    endtask

    initial begin
        test_reset;
        test_write_blocked;
        test_eral;
        test_write;
        test_read;
        test_ewds;
        test_abort;
        test_wrap;
        test_wral;
        test_host;
        test_reset_busy;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
